// File: rtl/serial_subtractor_8bits_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding, default width
// and the signed-overflow helper used when the final result bit is produced.
package serial_subtractor_8bits_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Overflow when operand signs differ and the result sign differs from A.
   function automatic logic signed_ovf(input logic a_msb,
                                       input logic b_msb,
                                       input logic d_msb);
      return (a_msb ^ b_msb) & (d_msb ^ a_msb);
   endfunction

endpackage

// File: rtl/serial_subtractor_8bits_if.sv
// Request/result bundle of the serial subtractor; master drives operands and
// start, slave returns status and the registered result.
interface serial_subtractor_8bits_if
   import serial_subtractor_8bits_pkg::*;
#(
   parameter int WIDTH = DATA_W
);

   logic             start;
   logic [WIDTH-1:0] minuend;
   logic [WIDTH-1:0] subtrahend;
   logic             borrow_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] difference;
   logic             borrow_out;
   logic             overflow;

   modport master (
      output start, minuend, subtrahend, borrow_in,
      input  busy, done, difference, borrow_out, overflow
   );

   modport slave (
      input  start, minuend, subtrahend, borrow_in,
      output busy, done, difference, borrow_out, overflow
   );

endinterface

// File: rtl/serial_subtractor_8bits_full_subtractor.sv
// Single-bit full subtractor cell: Diff = A - B - B_in, B_out is the borrow
// propagated to the next more significant bit.
module serial_subtractor_8bits_full_subtractor (
   input  logic A,
   input  logic B,
   input  logic B_in,
   output logic Diff,
   output logic B_out
);

   assign Diff  = A ^ B ^ B_in;
   assign B_out = (~A & B) | (~(A ^ B) & B_in);

endmodule

// File: rtl/serial_subtractor_8bits.sv
// Bit-serial subtractor: LSB-first through one full-subtractor cell, one bit
// per clock, with a start/busy/done handshake and held registered results.
module serial_subtractor_8bits
   import serial_subtractor_8bits_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   serial_subtractor_8bits_if.slave bus
);

   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bw_q, bw_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             cell_d_s;
   logic             cell_bw_s;
   logic             last_s;
   logic             accept_s;

   serial_subtractor_8bits_full_subtractor u_cell (
      .A     (a_q[0]),
      .B     (b_q[0]),
      .B_in  (bw_q),
      .Diff  (cell_d_s),
      .B_out (cell_bw_s)
   );

   assign last_s   = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
   assign accept_s = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_SHIFT;
            else           state_d = ST_IDLE;
         end
         ST_SHIFT: begin
            if (last_s) state_d = ST_DONE;
            else        state_d = ST_SHIFT;
         end
         ST_DONE: begin
            if (bus.start) state_d = ST_SHIFT;
            else           state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and status next values
   always_comb begin
      cnt_d  = cnt_q;
      a_d    = a_q;
      b_d    = b_q;
      bw_d   = bw_q;
      res_d  = res_q;
      diff_d = diff_q;
      bout_d = bout_q;
      ovf_d  = ovf_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept_s) begin
               a_d   = bus.minuend;
               b_d   = bus.subtrahend;
               bw_d  = bus.borrow_in;
               cnt_d = {CNT_W{1'b0}};
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_SHIFT: begin
            a_d   = {1'b0, a_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            bw_d  = cell_bw_s;
            res_d = {cell_d_s, res_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_ONE;
            // On the last bit the cell still sees the original operand MSBs.
            if (last_s) begin
               diff_d = {cell_d_s, res_q[WIDTH-1:1]};
               bout_d = cell_bw_s;
               ovf_d  = signed_ovf(a_q[0], b_q[0], cell_d_s);
            end else begin
               diff_d = diff_q;
            end
         end
         default: begin
            cnt_d = {CNT_W{1'b0}};
         end
      endcase
      busy_d = (state_d == ST_SHIFT);
      done_d = (state_d == ST_DONE);
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= {CNT_W{1'b0}};
         a_q    <= {WIDTH{1'b0}};
         b_q    <= {WIDTH{1'b0}};
         bw_q   <= 1'b0;
         res_q  <= {WIDTH{1'b0}};
         diff_q <= {WIDTH{1'b0}};
         bout_q <= 1'b0;
         ovf_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         a_q    <= a_d;
         b_q    <= b_d;
         bw_q   <= bw_d;
         res_q  <= res_d;
         diff_q <= diff_d;
         bout_q <= bout_d;
         ovf_q  <= ovf_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.difference = diff_q;
   assign bus.borrow_out = bout_q;
   assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_8bits.sv
// Self-checking bench for serial_subtractor_8bits: directed vector table,
// hand-written abort/ignore/back-to-back sequences and a random regression.
module tb_serial_subtractor_8bits;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] exp_d;
      logic         exp_bo;
      logic         exp_ov;
   } vec_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   logic [W-1:0] last_diff;

   serial_subtractor_8bits_if #(.WIDTH(W)) bus ();

   serial_subtractor_8bits #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer subtraction, overflow from operand/result signs.
   function automatic void ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic bin, output logic [W-1:0] d,
                                   output logic bo, output logic ov);
      int full;
      full = int'(a) - int'(b) - int'(bin);
      d    = full[W-1:0];
      bo   = (full < 0);
      ov   = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
   endfunction

   // Drives one operation from the current cycle; returns in its done cycle.
   // inj > 0 pulses a competing start with 0xFF-0xFF in that SHIFT cycle.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input logic [W-1:0] ed, input logic eb, input logic eo,
                         input int inj);
      bus.start      = 1'b1;
      bus.minuend    = a;
      bus.subtrahend = b;
      bus.borrow_in  = bin;
      tick();
      bus.start      = 1'b0;
      bus.minuend    = W'($urandom);
      bus.subtrahend = W'($urandom);
      bus.borrow_in  = 1'($urandom);
      chk("hold_diff", bus.difference, last_diff);
      for (int i = 1; i <= W; i++) begin
         chk("busy", bus.busy, 1'b1);
         chk("no_done", bus.done, 1'b0);
         if (i == inj) begin
            bus.start      = 1'b1;
            bus.minuend    = 8'hFF;
            bus.subtrahend = 8'hFF;
         end
         tick();
         bus.start = 1'b0;
      end
      chk("done", bus.done, 1'b1);
      chk("busy_off", bus.busy, 1'b0);
      chk("diff", bus.difference, ed);
      chk("borrow_out", bus.borrow_out, eb);
      chk("overflow", bus.overflow, eo);
      last_diff = ed;
   endtask

   initial begin
      vec_t vt[6];
      logic [W-1:0] ra, rb, rd;
      logic rbin, rbo, rov;
      bit saw_done;

      total = 0;
      bad = 0;
      last_diff = 8'h00;
      vt[0] = '{8'h64, 8'h37, 1'b0, 8'h2D, 1'b0, 1'b0};
      vt[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
      vt[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      vt[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
      vt[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
      vt[5] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0};

      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.minuend = 8'h00;
      bus.subtrahend = 8'h00;
      bus.borrow_in = 1'b0;
      repeat (3) tick();
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_diff", bus.difference, 8'h00);
      chk("rst_bo", bus.borrow_out, 1'b0);
      chk("rst_ov", bus.overflow, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", bus.busy, 1'b0);

      // Directed table, each op followed by a return to IDLE
      for (int k = 0; k < 6; k++) begin
         run_op(vt[k].a, vt[k].b, vt[k].bin, vt[k].exp_d, vt[k].exp_bo, vt[k].exp_ov, 0);
         tick();
         chk("done_pulse_end", bus.done, 1'b0);
         chk("idle_after", bus.busy, 1'b0);
         chk("idle_hold", bus.difference, vt[k].exp_d);
      end

      // start during SHIFT is ignored
      run_op(8'h55, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0, 3);
      tick();
      chk("ignored_start_idle", bus.busy, 1'b0);

      // Reset in SHIFT cycle 4 aborts with no done
      bus.start = 1'b1;
      bus.minuend = 8'h33;
      bus.subtrahend = 8'h01;
      bus.borrow_in = 1'b0;
      tick();
      bus.start = 1'b0;
      repeat (3) tick();
      chk("pre_abort_busy", bus.busy, 1'b1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_done", bus.done, 1'b0);
      chk("abort_diff", bus.difference, 8'h00);
      saw_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (bus.done) saw_done = 1'b1;
         tick();
      end
      chk("abort_no_done", saw_done, 1'b0);
      last_diff = 8'h00;

      // Back-to-back: second start held during the first done cycle
      run_op(8'h09, 8'h02, 1'b0, 8'h07, 1'b0, 1'b0, 0);
      run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 0);

      // Random regression, all back-to-back
      for (int n = 0; n < 1000; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rbin = 1'($urandom);
         ref_sub(ra, rb, rbin, rd, rbo, rov);
         run_op(ra, rb, rbin, rd, rbo, rov, 0);
      end
      tick();
      chk("final_idle", bus.busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
